// File: rtl/pipeline_ctrl.sv
// Purpose: merges ID/EX/MEM stall requests, load-use hazard and multi-cycle EX sequencing into per-stage holds; owns the delay-slot flag.
// Latency: stall_o is combinational (zero cycles); flush_o/mc_abort_o/mc_busy_o/id_in_delayslot_o are registered (one cycle).
// Backpressure: upstream stages are held via stall_o (bit 0 = PC); an abort flushes instead of stalling. Optional perf counter: PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int MC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stallreq_i,
  input  logic        ex_stallreq_i,
  input  logic        mem_stallreq_i,
  input  logic        ex_is_load_i,
  input  logic [4:0]  ex_wreg_addr_i,
  input  logic        id_r1_en_i,
  input  logic        id_r2_en_i,
  input  logic [4:0]  id_r1_addr_i,
  input  logic [4:0]  id_r2_addr_i,
  input  logic        ex_mc_start_i,
  input  logic        mc_done_i,
  input  logic        id_next_in_delayslot_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        mc_busy_o,
  output logic        mc_abort_o,
  output logic        id_in_delayslot_o,
  output logic [31:0] stall_cycles_o
);

  // Counter only needs to reach MC_TIMEOUT-1.
  localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

  // Stall vector encodings, bit order {WB,MEM,EX,ID,IF,PC}.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] mc_cnt;
  logic             load_use;
  logic             mc_stall;

  // Load-use: the loaded value is not available for forwarding until MEM, so ID must wait one cycle.
  always_comb begin
    load_use = 1'b0;
    if (ex_is_load_i && (ex_wreg_addr_i != 5'd0)) begin
      load_use = (id_r1_en_i && (id_r1_addr_i == ex_wreg_addr_i)) ||
                 (id_r2_en_i && (id_r2_addr_i == ex_wreg_addr_i));
    end
  end

  // EX must hold while the multi-cycle unit is working, including the issue cycle itself unless it finishes at once.
  always_comb begin
    mc_stall = 1'b0;
    case (state)
      ST_IDLE: mc_stall = ex_mc_start_i && !mc_done_i;
      ST_BUSY: mc_stall = !mc_done_i;
      default: mc_stall = 1'b0;
    endcase
  end

  // Priority-merge stall sources; an abort cycle never stalls so the flush can propagate.
  always_comb begin
    stall_o = STALL_NONE;
    if (state != ST_ABORT) begin
      if (mem_stallreq_i) begin
        stall_o = STALL_MEM;
      end else if (ex_stallreq_i || mc_stall) begin
        stall_o = STALL_EX;
      end else if (id_stallreq_i || load_use) begin
        stall_o = STALL_ID;
      end
    end
  end

  // Multi-cycle sequencer with timeout; status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mc_cnt     <= '0;
      flush_o    <= 1'b0;
      mc_abort_o <= 1'b0;
      mc_busy_o  <= 1'b0;
    end else begin
      flush_o    <= 1'b0;
      mc_abort_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Start with simultaneous done is a single-cycle op: nothing to track.
          if (ex_mc_start_i && !mc_done_i) begin
            state     <= ST_BUSY;
            mc_cnt    <= '0;
            mc_busy_o <= 1'b1;
          end
        end
        ST_BUSY: begin
          // Done takes precedence over an expiring counter in the same cycle.
          if (mc_done_i) begin
            state     <= ST_IDLE;
            mc_busy_o <= 1'b0;
          end else if (mc_cnt == CNT_LAST) begin
            state      <= ST_ABORT;
            mc_busy_o  <= 1'b0;
            flush_o    <= 1'b1;
            mc_abort_o <= 1'b1;
          end else begin
            mc_cnt <= mc_cnt + 1'b1;
          end
        end
        ST_ABORT: begin
          state <= ST_IDLE;
        end
        default: begin
          state     <= ST_IDLE;
          mc_busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Delay-slot flag follows ID unless ID is held; a flush discards it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_in_delayslot_o <= 1'b0;
    end else if (flush_o) begin
      id_in_delayslot_o <= 1'b0;
    end else if (!stall_o[2]) begin
      id_in_delayslot_o <= id_next_in_delayslot_i;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt;

  // Count cycles in which the PC is held; saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall_o[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles_o = stall_cnt;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Purpose: directed checks of pipeline_ctrl with a short timeout (MC_TIMEOUT=4).
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: none; the bench drives every input each cycle.
module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        id_stallreq_i;
  logic        ex_stallreq_i;
  logic        mem_stallreq_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_wreg_addr_i;
  logic        id_r1_en_i;
  logic        id_r2_en_i;
  logic [4:0]  id_r1_addr_i;
  logic [4:0]  id_r2_addr_i;
  logic        ex_mc_start_i;
  logic        mc_done_i;
  logic        id_next_in_delayslot_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic        mc_busy_o;
  logic        mc_abort_o;
  logic        id_in_delayslot_o;
  logic [31:0] stall_cycles_o;

  int total;
  int bad;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd5;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  pipeline_ctrl #(.MC_TIMEOUT(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .id_stallreq_i          (id_stallreq_i),
    .ex_stallreq_i          (ex_stallreq_i),
    .mem_stallreq_i         (mem_stallreq_i),
    .ex_is_load_i           (ex_is_load_i),
    .ex_wreg_addr_i         (ex_wreg_addr_i),
    .id_r1_en_i             (id_r1_en_i),
    .id_r2_en_i             (id_r2_en_i),
    .id_r1_addr_i           (id_r1_addr_i),
    .id_r2_addr_i           (id_r2_addr_i),
    .ex_mc_start_i          (ex_mc_start_i),
    .mc_done_i              (mc_done_i),
    .id_next_in_delayslot_i (id_next_in_delayslot_i),
    .stall_o                (stall_o),
    .flush_o                (flush_o),
    .mc_busy_o              (mc_busy_o),
    .mc_abort_o             (mc_abort_o),
    .id_in_delayslot_o      (id_in_delayslot_o),
    .stall_cycles_o         (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst                    = 1'b0;
    id_stallreq_i          = 1'b0;
    ex_stallreq_i          = 1'b0;
    mem_stallreq_i         = 1'b0;
    ex_is_load_i           = 1'b0;
    ex_wreg_addr_i         = 5'd0;
    id_r1_en_i             = 1'b0;
    id_r2_en_i             = 1'b0;
    id_r1_addr_i           = 5'd0;
    id_r2_addr_i           = 5'd0;
    ex_mc_start_i          = 1'b0;
    mc_done_i              = 1'b0;
    id_next_in_delayslot_i = 1'b0;

    // Reset values
    #12;
    chk("rst_stall", {26'd0, stall_o}, 32'd0);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_busy",  {31'd0, mc_busy_o}, 32'd0);
    chk("rst_abort", {31'd0, mc_abort_o}, 32'd0);
    chk("rst_ds",    {31'd0, id_in_delayslot_o}, 32'd0);
    chk("rst_perf",  stall_cycles_o, 32'd0);
    #5 rst = 1'b1;
    step();

    // Load-use hazard on r1, then with $0 destination, then on r2
    ex_is_load_i = 1'b1; ex_wreg_addr_i = 5'd5; id_r1_en_i = 1'b1; id_r1_addr_i = 5'd5;
    #1 chk("lu_r1", {26'd0, stall_o}, 32'h07);
    ex_wreg_addr_i = 5'd0; id_r1_addr_i = 5'd0;
    #1 chk("lu_zero", {26'd0, stall_o}, 32'h00);
    id_r1_en_i = 1'b0; ex_wreg_addr_i = 5'd9; id_r2_en_i = 1'b1; id_r2_addr_i = 5'd9;
    #1 chk("lu_r2", {26'd0, stall_o}, 32'h07);
    id_r2_en_i = 1'b0;
    #1 chk("lu_r2_dis", {26'd0, stall_o}, 32'h00);
    ex_is_load_i = 1'b0;
    step();

    // Priority merge
    mem_stallreq_i = 1'b1; ex_stallreq_i = 1'b1; id_stallreq_i = 1'b1;
    #1 chk("pri_all", {26'd0, stall_o}, 32'h1F);
    mem_stallreq_i = 1'b0;
    #1 chk("pri_ex", {26'd0, stall_o}, 32'h0F);
    ex_stallreq_i = 1'b0;
    #1 chk("pri_id", {26'd0, stall_o}, 32'h07);
    id_stallreq_i = 1'b0;
    #1 chk("pri_none", {26'd0, stall_o}, 32'h00);
    step();

    // Delay slot: held while ID stalls, loaded once released
    id_stallreq_i = 1'b1; id_next_in_delayslot_i = 1'b1;
    step();
    chk("ds_hold", {31'd0, id_in_delayslot_o}, 32'd0);
    id_stallreq_i = 1'b0;
    step();
    chk("ds_load", {31'd0, id_in_delayslot_o}, 32'd1);
    id_next_in_delayslot_i = 1'b0;
    step();
    chk("ds_clr", {31'd0, id_in_delayslot_o}, 32'd0);

    // Multi-cycle: start at N, done at N+4 (also the expiring-counter cycle)
    ex_mc_start_i = 1'b1;
    #1 chk("mc_issue", {26'd0, stall_o}, 32'h0F);
    step();
    ex_mc_start_i = 1'b0;
    chk("mc_busy1", {31'd0, mc_busy_o}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("mc_stall", {26'd0, stall_o}, 32'h0F);
      step();
    end
    mc_done_i = 1'b1;
    #1 chk("mc_done_stall", {26'd0, stall_o}, 32'h00);
    step();
    mc_done_i = 1'b0;
    chk("mc_idle_busy",  {31'd0, mc_busy_o}, 32'd0);
    chk("mc_idle_abort", {31'd0, mc_abort_o}, 32'd0);

    // Start and done together: no stall, no BUSY
    ex_mc_start_i = 1'b1; mc_done_i = 1'b1;
    #1 chk("mc_1cyc_stall", {26'd0, stall_o}, 32'h00);
    step();
    ex_mc_start_i = 1'b0; mc_done_i = 1'b0;
    chk("mc_1cyc_busy", {31'd0, mc_busy_o}, 32'd0);

    // Timeout: delay-slot flag set beforehand, must be cleared by the flush
    id_next_in_delayslot_i = 1'b1;
    step();
    chk("to_ds_pre", {31'd0, id_in_delayslot_o}, 32'd1);
    ex_mc_start_i = 1'b1;
    step();
    ex_mc_start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_busy",  {31'd0, mc_busy_o}, 32'd1);
      chk("to_flush", {31'd0, flush_o}, 32'd0);
      chk("to_stall", {26'd0, stall_o}, 32'h0F);
      step();
    end
    mem_stallreq_i = 1'b1;
    #1;
    chk("ab_flush", {31'd0, flush_o}, 32'd1);
    chk("ab_abort", {31'd0, mc_abort_o}, 32'd1);
    chk("ab_stall", {26'd0, stall_o}, 32'h00);
    chk("ab_busy",  {31'd0, mc_busy_o}, 32'd0);
    step();
    mem_stallreq_i = 1'b0;
    chk("ab_flush_end", {31'd0, flush_o}, 32'd0);
    chk("ab_abort_end", {31'd0, mc_abort_o}, 32'd0);
    chk("ab_ds_clr",    {31'd0, id_in_delayslot_o}, 32'd0);
    id_next_in_delayslot_i = 1'b0;
    step();

    // Asynchronous reset in the middle of BUSY
    ex_mc_start_i = 1'b1;
    step();
    ex_mc_start_i = 1'b0;
    chk("ar_busy_pre", {31'd0, mc_busy_o}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy",  {31'd0, mc_busy_o}, 32'd0);
    chk("ar_stall", {26'd0, stall_o}, 32'h00);
    chk("ar_flush", {31'd0, flush_o}, 32'd0);
    chk("ar_ds",    {31'd0, id_in_delayslot_o}, 32'd0);
    chk("ar_perf",  stall_cycles_o, 32'd0);
    #2 rst = 1'b1;
    step();
    chk("ar_stay_idle", {31'd0, mc_busy_o}, 32'd0);

    // Performance counter after a 5-cycle ID stall
    id_stallreq_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    id_stallreq_i = 1'b0;
    chk("perf_5", stall_cycles_o, PERF_EXP);
    step();
    chk("perf_hold", stall_cycles_o, PERF_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline stall/flush controller for the five-stage MIPS core. It merges stall requests from ID, EX and MEM into one per-stage stall vector. It also detects load-use hazards that the ID forwarding paths cannot cover and sequences multi-cycle EX operations (divider) through a start/done handshake with a timeout abort. It owns the branch-delay-slot flag register between ID's `id_next_in_delayslot_o` output and its `id_in_delayslot_i` input.

## Interface
- `MC_TIMEOUT`, 64: maximum BUSY cycles before the multi-cycle op is aborted (≥2).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `id_stallreq_i`  in  1  stall request from ID.
- `ex_stallreq_i`  in  1  single-cycle stall request from EX.
- `mem_stallreq_i`  in  1  stall request from MEM (data bus wait).
- `ex_is_load_i`  in  1  instruction in EX is LB/LW.
- `ex_wreg_addr_i`  in  5  destination register of EX instruction.
- `id_r1_en_i`, `id_r2_en_i`  in  1  ID read-port enables.
- `id_r1_addr_i`, `id_r2_addr_i`  in  5  ID read-port addresses.
- `ex_mc_start_i`  in  1  EX issues a multi-cycle op this cycle.
- `mc_done_i`  in  1  multi-cycle unit result valid.
- `id_next_in_delayslot_i`  in  1  ID decoded a branch/jump.
- `stall_o`  out  6  {WB,MEM,EX,ID,IF,PC} hold enables; bit 0 = PC.
- `flush_o`  out  1  one-cycle pipeline flush (abort).
- `mc_busy_o`  out  1  multi-cycle op in flight.
- `mc_abort_o`  out  1  one-cycle pulse on timeout.
- `id_in_delayslot_o`  out  1  registered delay-slot flag to ID.
- `stall_cycles_o`  out  32  performance counter (see Configuration).

## Operation
- FSM states: IDLE, BUSY, ABORT. Reset → IDLE.
- IDLE: `ex_mc_start_i`=1 and `mc_done_i`=0 → BUSY, timeout counter cleared. Start and done in the same cycle → stay IDLE; this is a single-cycle completion with no stall.
- BUSY: `mc_done_i`=1 → IDLE. Otherwise the counter increments. When counter reaches `MC_TIMEOUT`-1 without done → ABORT. `ex_mc_start_i` in BUSY is ignored.
- ABORT: `flush_o`=1 and `mc_abort_o`=1 for exactly one cycle, stall_o=0, then → IDLE.
- Load-use hazard: `ex_is_load_i` and (r1_en & r1_addr==ex_wreg_addr, or r2_en & r2_addr==ex_wreg_addr), with ex_wreg_addr≠0.
- Stall priority, highest first, evaluated combinationally:
  - `mem_stallreq_i` → 011111.
  - `ex_stallreq_i`, state BUSY with `mc_done_i`=0, or IDLE start without done → 001111.
  - `id_stallreq_i` or load-use → 000111.
  - otherwise → 000000.
- In ABORT, stall_o=0 regardless of requests.
- `mc_busy_o` = (state==BUSY).
- Delay-slot register: loads `id_next_in_delayslot_i` when stall_o[2]=0; holds when stall_o[2]=1; cleared when `flush_o`=1.

## Timing
- Reset values: stall_o=0, flush_o=0, mc_busy_o=0, mc_abort_o=0, id_in_delayslot_o=0, stall_cycles_o=0, counter=0.
- Reset is asynchronous and can assert mid-operation. BUSY/ABORT go immediately to IDLE and pending state is discarded.
- stall_o and the hazard path are combinational from inputs plus registered state, with zero-cycle latency.
- Multi-cycle op: start at cycle N, done at cycle N+k → stall_o=001111 in cycles N..N+k-1 and 0 in cycle N+k; state is IDLE at N+k+1.
- Timeout: no done → BUSY for `MC_TIMEOUT` cycles, ABORT on the following cycle.
- `mc_done_i` arriving in the cycle the counter expires wins: → IDLE, no abort.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: `stall_cycles_o` increments every cycle with stall_o[0]=1 and saturates at 0xFFFF_FFFF. It clears only on reset.
- Not defined: `stall_cycles_o` is tied to 0 and no counter flops exist. The port remains present.

## Test plan
- Load-use: EX LW writes $5, ID reads r1=$5 → stall_o=000111 for one cycle. Same with ex_wreg=$0 → stall_o=0.
- Multi-cycle: start at cycle 10, done at cycle 14 → stall_o=001111 in cycles 10–13, 0 at 14, mc_busy_o 0 at 15.
- Timeout with `MC_TIMEOUT`=4 and no done → flush_o and mc_abort_o pulse once after 4 BUSY cycles, id_in_delayslot_o cleared.
- Priority: mem_stallreq, ex_stallreq and id_stallreq all asserted together → 011111. Drop mem_stallreq → 001111.
- Delay slot: next_in_delayslot=1 while stall_o[2]=1 → output unchanged. Stall released → output 1 next cycle.
- Reset asserted during BUSY → all outputs 0 asynchronously. With `PIPE_CTRL_PERF_EN`, stall_cycles_o counts 5 after a 5-cycle ID stall.
